axis_ring_fifo: RTL and testbench

Parametrised successor to the team's shift-register axis FIFO. It uses a circular buffer with read and write pointers, so depth scales without shifting every entry on each push. It also adds a level output, an almost-full flag, a synchronous flush and an optional packet mode. It sits between axis producers and consumers wherever elastic buffering deeper than a few words is needed; all outputs are registered.

---
 rtl/axis_ring_fifo.sv | 198 +++++++++++++++++++
 tb/tb_axis_ring_fifo.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_ring_fifo.sv
// ---------------------------------------------------------------------------
// axis_ring_fifo
//
// Elastic AXI-stream buffer built on a circular RAM plus a registered head
// word. The head of the queue always lives in the odata register so that
// every output is driven straight from a flop; the remaining DEPTH-1 words
// sit in a RAM addressed by wrapping read/write pointers, so depth can grow
// without shifting entries.
//
// Optional feature macro: AXIS_RING_FIFO_PACKET_EN
//   When defined, ilast/olast exist, a last bit travels with every word, and
//   ovalid is withheld until a complete packet is buffered (or the FIFO is
//   full, so that packets longer than DEPTH cannot deadlock).
//
// Parameters:
//   WIDTH        data word width
//   DEPTH        total capacity in words (>= 2, any integer), head included
//   ALMOST_FULL  level threshold for almost_full (1..DEPTH)
//   LEVEL_WIDTH  width of the level output
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-high reset
//   clear        synchronous flush, wins over any handshake in that cycle
//   level        number of words currently held
//   almost_full  level >= ALMOST_FULL
//   idata/ivalid/iready   input stream
//   odata/ovalid/oready   output stream (odata registered)
//   ilast/olast  packet boundary, packet mode only
// ---------------------------------------------------------------------------
module axis_ring_fifo #(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 16,
   parameter int ALMOST_FULL = DEPTH - 2,
   parameter int LEVEL_WIDTH = $clog2(DEPTH + 1)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   clear,
   output logic [LEVEL_WIDTH-1:0] level,
   output logic                   almost_full,
   input  logic [WIDTH-1:0]       idata,
   input  logic                   ivalid,
   output logic                   iready,
   output logic [WIDTH-1:0]       odata,
   output logic                   ovalid,
   input  logic                   oready
`ifdef AXIS_RING_FIFO_PACKET_EN
   ,
   input  logic                   ilast,
   output logic                   olast
`endif
);

   localparam int RAM_DEPTH = DEPTH - 1;
   localparam int PTR_WIDTH = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
   localparam logic [PTR_WIDTH-1:0]   PTR_LAST   = PTR_WIDTH'(RAM_DEPTH - 1);
   localparam logic [LEVEL_WIDTH-1:0] LEVEL_FULL = LEVEL_WIDTH'(DEPTH);
   localparam logic [LEVEL_WIDTH-1:0] LEVEL_AF   = LEVEL_WIDTH'(ALMOST_FULL);
   localparam logic [LEVEL_WIDTH-1:0] LEVEL_ONE  = LEVEL_WIDTH'(1);

   logic [LEVEL_WIDTH-1:0] r_level;
   logic                   r_iready;
   logic                   r_ovalid;
   logic                   r_almostFull;
   logic [WIDTH-1:0]       r_odata;
   logic [PTR_WIDTH-1:0]   r_wp;
   logic [PTR_WIDTH-1:0]   r_rp;
   logic [WIDTH-1:0]       r_mem [RAM_DEPTH];

   logic                   w_push;
   logic                   w_pop;
   logic [LEVEL_WIDTH-1:0] w_nLevel;
   logic                   w_bypass;
   logic                   w_ramWrite;
   logic                   w_ramRead;
   logic                   w_nValid;

`ifdef AXIS_RING_FIFO_PACKET_EN
   logic                   r_memLast [RAM_DEPTH];
   logic                   r_olast;
   logic [LEVEL_WIDTH-1:0] r_packets;
   logic [LEVEL_WIDTH-1:0] w_nPackets;
`endif

   // Pointers cover only the RAM part of the storage, so they wrap after
   // RAM_DEPTH entries rather than at a power of two.
   function automatic logic [PTR_WIDTH-1:0] nextPtr(input logic [PTR_WIDTH-1:0] ptr);
      return (ptr == PTR_LAST) ? '0 : ptr + PTR_WIDTH'(1);
   endfunction

   assign level       = r_level;
   assign iready      = r_iready;
   assign ovalid      = r_ovalid;
   assign almost_full = r_almostFull;
   assign odata       = r_odata;
`ifdef AXIS_RING_FIFO_PACKET_EN
   assign olast       = r_olast;
`endif

   // Handshakes only look at registered ready/valid, which keeps every
   // output free of combinational paths from ivalid or oready.
   assign w_push   = ivalid && r_iready;
   assign w_pop    = r_ovalid && oready;
   assign w_nLevel = r_level + LEVEL_WIDTH'(w_push) - LEVEL_WIDTH'(w_pop);

   // The head register takes the input word directly whenever the RAM holds
   // nothing that should come out first: an empty FIFO, or a single word
   // that is leaving in the same cycle. Otherwise pushes go to the RAM and
   // pops refill the head from the RAM.
   assign w_bypass   = w_push && ((r_level == '0) || ((r_level == LEVEL_ONE) && w_pop));
   assign w_ramWrite = w_push && !w_bypass;
   assign w_ramRead  = w_pop && (r_level > LEVEL_ONE);

   // Output valid for the next cycle. In packet mode a partial packet is
   // held back unless the FIFO is full, which is the only way a packet
   // longer than the FIFO can make progress.
   always_comb begin
`ifdef AXIS_RING_FIFO_PACKET_EN
      w_nPackets = r_packets + LEVEL_WIDTH'(w_push && ilast) - LEVEL_WIDTH'(w_pop && r_olast);
      w_nValid   = (w_nLevel != '0) && ((w_nPackets != '0) || (w_nLevel == LEVEL_FULL));
`else
      w_nValid   = (w_nLevel != '0);
`endif
   end

   // Control and head-word registers. clear empties the FIFO and drops any
   // handshake of its cycle but leaves the stale head word in place, since
   // ovalid already marks it as meaningless.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_level      <= '0;
         r_iready     <= 1'b0;
         r_ovalid     <= 1'b0;
         r_almostFull <= 1'b0;
         r_odata      <= '0;
         r_wp         <= '0;
         r_rp         <= '0;
      end else if (clear) begin
         r_level      <= '0;
         r_iready     <= 1'b1;
         r_ovalid     <= 1'b0;
         r_almostFull <= 1'b0;
         r_wp         <= '0;
         r_rp         <= '0;
      end else begin
         r_level      <= w_nLevel;
         r_iready     <= (w_nLevel < LEVEL_FULL);
         r_ovalid     <= w_nValid;
         r_almostFull <= (w_nLevel >= LEVEL_AF);
         if (w_bypass) begin
            r_odata <= idata;
         end else if (w_ramRead) begin
            r_odata <= r_mem[r_rp];
         end
         if (w_ramRead) begin
            r_rp <= nextPtr(r_rp);
         end
         if (w_ramWrite) begin
            r_wp <= nextPtr(r_wp);
         end
      end
   end

   // Storage array has no reset: its contents are only ever read behind a
   // valid level count, and leaving it unreset lets it map onto RAM cells.
   // While reset is high iready is low, so no write can be issued.
   always_ff @(posedge clock) begin
      if (w_ramWrite && !clear) begin
         r_mem[r_wp] <= idata;
`ifdef AXIS_RING_FIFO_PACKET_EN
         r_memLast[r_wp] <= ilast;
`endif
      end
   end

`ifdef AXIS_RING_FIFO_PACKET_EN
   // Packet bookkeeping: olast follows the head word through the same
   // bypass/refill paths as odata, and the counter tracks how many complete
   // packets are buffered.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_olast   <= 1'b0;
         r_packets <= '0;
      end else if (clear) begin
         r_packets <= '0;
      end else begin
         r_packets <= w_nPackets;
         if (w_bypass) begin
            r_olast <= ilast;
         end else if (w_ramRead) begin
            r_olast <= r_memLast[r_rp];
         end
      end
   end
`endif

endmodule

// File: tb/tb_axis_ring_fifo.sv
// ---------------------------------------------------------------------------
// tb_axis_ring_fifo
//
// Self-checking bench for axis_ring_fifo. Instance A (DEPTH=16) runs a
// table of single-cycle vectors (fill to full, drain, clear) plus streaming
// and asynchronous-reset sequences. Instance B (DEPTH=5) runs randomized
// traffic against a queue-based reference model. Instance C (DEPTH=8, only
// with AXIS_RING_FIFO_PACKET_EN) covers packet release rules.
// ---------------------------------------------------------------------------
module tb_axis_ring_fifo;

   typedef struct {
      logic       ivalid;
      logic [7:0] idata;
      logic       oready;
      logic       clear;
      int         expLevel;
      logic       expIready;
      logic       expOvalid;
      logic       expAf;
      logic [7:0] expOdata;
   } vec_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Instance A signals
   logic       aReset, aClear, aAf, aIvalid, aIready, aOvalid, aOready;
   logic [4:0] aLevel;
   logic [7:0] aIdata, aOdata;
   // Instance B signals
   logic       bReset, bClear, bAf, bIvalid, bIready, bOvalid, bOready;
   logic [2:0] bLevel;
   logic [7:0] bIdata, bOdata;
`ifdef AXIS_RING_FIFO_PACKET_EN
   logic       aOlast, bOlast;
   logic       cReset, cClear, cAf, cIvalid, cIready, cOvalid, cOready, cIlast, cOlast;
   logic [3:0] cLevel;
   logic [7:0] cIdata, cOdata;
`endif

   vec_t       vecs[$];
   logic [7:0] modelQ[$];
   logic       mIready, mOvalid, mPush, mPop;
   int         pIn, pOut;
   logic [7:0] streamData;

   axis_ring_fifo #(.WIDTH(8), .DEPTH(16)) dutA (
      .clock(clock), .reset(aReset), .clear(aClear), .level(aLevel),
      .almost_full(aAf), .idata(aIdata), .ivalid(aIvalid), .iready(aIready),
      .odata(aOdata), .ovalid(aOvalid), .oready(aOready)
`ifdef AXIS_RING_FIFO_PACKET_EN
      , .ilast(1'b1), .olast(aOlast)
`endif
   );

   axis_ring_fifo #(.WIDTH(8), .DEPTH(5), .ALMOST_FULL(3)) dutB (
      .clock(clock), .reset(bReset), .clear(bClear), .level(bLevel),
      .almost_full(bAf), .idata(bIdata), .ivalid(bIvalid), .iready(bIready),
      .odata(bOdata), .ovalid(bOvalid), .oready(bOready)
`ifdef AXIS_RING_FIFO_PACKET_EN
      , .ilast(1'b1), .olast(bOlast)
`endif
   );

`ifdef AXIS_RING_FIFO_PACKET_EN
   axis_ring_fifo #(.WIDTH(8), .DEPTH(8)) dutC (
      .clock(clock), .reset(cReset), .clear(cClear), .level(cLevel),
      .almost_full(cAf), .idata(cIdata), .ivalid(cIvalid), .iready(cIready),
      .odata(cOdata), .ovalid(cOvalid), .oready(cOready),
      .ilast(cIlast), .olast(cOlast)
   );
`endif

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic addVec(input logic iv, input logic [7:0] id, input logic ordy, input logic clr,
                         input int lvl, input logic ir, input logic ov, input logic af, input logic [7:0] od);
      vec_t v;
      v.ivalid = iv; v.idata = id; v.oready = ordy; v.clear = clr;
      v.expLevel = lvl; v.expIready = ir; v.expOvalid = ov; v.expAf = af; v.expOdata = od;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v);
      aIvalid = v.ivalid;
      aIdata  = v.idata;
      aOready = v.oready;
      aClear  = v.clear;
   endtask

   // Expected values follow directly from occupancy: 16 words capacity,
   // almost_full at 14, head word is the oldest word still held.
   task automatic fillTable();
      for (int i = 0; i < 16; i++)
         addVec(1'b1, 8'(i + 1), 1'b0, 1'b0, i + 1, (i + 1 < 16), 1'b1, (i + 1 >= 14), 8'h01);
      addVec(1'b1, 8'h99, 1'b0, 1'b0, 16, 1'b0, 1'b1, 1'b1, 8'h01);
      for (int k = 0; k < 16; k++)
         addVec(1'b0, 8'h00, 1'b1, 1'b0, 15 - k, 1'b1, (15 - k > 0), (15 - k >= 14), 8'(k + 2));
      for (int i = 0; i < 7; i++)
         addVec(1'b1, 8'(8'h31 + i), 1'b0, 1'b0, i + 1, 1'b1, 1'b1, 1'b0, 8'h31);
      addVec(1'b1, 8'h77, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h00);
      addVec(1'b1, 8'hAA, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 8'hAA);
      addVec(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      aReset = 1'b1; aClear = 1'b0; aIvalid = 1'b0; aOready = 1'b0; aIdata = 8'h00;
      bReset = 1'b1; bClear = 1'b0; bIvalid = 1'b0; bOready = 1'b0; bIdata = 8'h00;
`ifdef AXIS_RING_FIFO_PACKET_EN
      cReset = 1'b1; cClear = 1'b0; cIvalid = 1'b0; cOready = 1'b0; cIdata = 8'h00; cIlast = 1'b0;
`endif
      fillTable();

      // Reset state
      #12;
      checkOutput("reset level", 32'(aLevel), 32'd0);
      checkOutput("reset iready", 32'(aIready), 32'd0);
      checkOutput("reset ovalid", 32'(aOvalid), 32'd0);
      checkOutput("reset almost_full", 32'(aAf), 32'd0);
      checkOutput("reset odata", 32'(aOdata), 32'h00);
      aReset = 1'b0; bReset = 1'b0;
`ifdef AXIS_RING_FIFO_PACKET_EN
      cReset = 1'b0;
`endif
      tick();
      checkOutput("post-reset iready", 32'(aIready), 32'd1);
      checkOutput("post-reset level", 32'(aLevel), 32'd0);

      // Table-driven vectors on instance A
      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         tick();
         checkOutput($sformatf("vec%0d level", i), 32'(aLevel), 32'(vecs[i].expLevel));
         checkOutput($sformatf("vec%0d iready", i), 32'(aIready), 32'(vecs[i].expIready));
         checkOutput($sformatf("vec%0d ovalid", i), 32'(aOvalid), 32'(vecs[i].expOvalid));
         checkOutput($sformatf("vec%0d almost_full", i), 32'(aAf), 32'(vecs[i].expAf));
         if (vecs[i].expOvalid)
            checkOutput($sformatf("vec%0d odata", i), 32'(aOdata), 32'(vecs[i].expOdata));
      end

      // Streaming at level 1: every cycle one word in, one word out
      aClear = 1'b0; aIvalid = 1'b1; aOready = 1'b0; aIdata = 8'hC0;
      tick();
      checkOutput("stream prime odata", 32'(aOdata), 32'hC0);
      aOready = 1'b1;
      for (int c = 0; c < 100; c++) begin
         streamData = 8'($urandom);
         aIdata = streamData;
         tick();
         checkOutput($sformatf("stream%0d odata", c), 32'(aOdata), 32'(streamData));
         checkOutput($sformatf("stream%0d level", c), 32'(aLevel), 32'd1);
         checkOutput($sformatf("stream%0d iready&ovalid", c), 32'(aIready && aOvalid), 32'd1);
      end

      // Asynchronous reset mid-stream, between clock edges
      #3;
      aReset = 1'b1;
      #1;
      checkOutput("async reset level", 32'(aLevel), 32'd0);
      checkOutput("async reset ovalid", 32'(aOvalid), 32'd0);
      checkOutput("async reset iready", 32'(aIready), 32'd0);
      aIvalid = 1'b0; aOready = 1'b0;
      #2;
      aReset = 1'b0;
      tick();
      checkOutput("after async reset iready", 32'(aIready), 32'd1);
      checkOutput("after async reset level", 32'(aLevel), 32'd0);

      // Randomized traffic on instance B against a queue model
      bReset = 1'b1;
      #1;
      bReset = 1'b0;
      mIready = 1'b0; mOvalid = 1'b0;
      modelQ.delete();
      for (int cyc = 0; cyc < 1000; cyc++) begin
         pIn  = ((cyc / 100) % 2 == 0) ? 80 : 30;
         pOut = ((cyc / 100) % 2 == 0) ? 30 : 80;
         bIvalid = ($urandom_range(0, 99) < pIn);
         bOready = ($urandom_range(0, 99) < pOut);
         bIdata  = 8'($urandom);
         bClear  = ($urandom_range(0, 63) == 0);
         mPush = bIvalid && mIready;
         mPop  = mOvalid && bOready;
         tick();
         if (bClear) begin
            modelQ.delete();
         end else begin
            if (mPop) void'(modelQ.pop_front());
            if (mPush) modelQ.push_back(bIdata);
         end
         mIready = (modelQ.size() < 5);
         mOvalid = (modelQ.size() > 0);
         checkOutput($sformatf("rnd%0d level", cyc), 32'(bLevel), 32'(modelQ.size()));
         checkOutput($sformatf("rnd%0d iready", cyc), 32'(bIready), 32'(mIready));
         checkOutput($sformatf("rnd%0d ovalid", cyc), 32'(bOvalid), 32'(mOvalid));
         checkOutput($sformatf("rnd%0d almost_full", cyc), 32'(bAf), 32'(modelQ.size() >= 3));
         if (modelQ.size() > 0)
            checkOutput($sformatf("rnd%0d odata", cyc), 32'(bOdata), 32'(modelQ[0]));
      end
      bIvalid = 1'b0; bOready = 1'b0; bClear = 1'b0;

`ifdef AXIS_RING_FIFO_PACKET_EN
      // Packet mode: 3-word packet held until its last word arrives
      cIvalid = 1'b1; cOready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cIdata = 8'(8'h50 + k);
         cIlast = (k == 2);
         tick();
         checkOutput($sformatf("pkt3 push%0d level", k), 32'(cLevel), 32'(k + 1));
         checkOutput($sformatf("pkt3 push%0d ovalid", k), 32'(cOvalid), 32'(k == 2));
      end
      checkOutput("pkt3 head olast", 32'(cOlast), 32'd0);
      cIvalid = 1'b0; cIlast = 1'b0; cOready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput($sformatf("pkt3 pop%0d ovalid", k), 32'(cOvalid), 32'(k < 2));
         if (k < 2) begin
            checkOutput($sformatf("pkt3 pop%0d odata", k), 32'(cOdata), 32'(8'h51 + k));
            checkOutput($sformatf("pkt3 pop%0d olast", k), 32'(cOlast), 32'(k == 1));
         end
      end

      // Packet longer than the FIFO: released only when full
      cOready = 1'b0; cIvalid = 1'b1; cIlast = 1'b0;
      for (int k = 0; k < 8; k++) begin
         cIdata = 8'(8'h60 + k);
         tick();
         checkOutput($sformatf("pkt9 push%0d ovalid", k), 32'(cOvalid), 32'(k == 7));
      end
      checkOutput("pkt9 full iready", 32'(cIready), 32'd0);
      checkOutput("pkt9 full odata", 32'(cOdata), 32'h60);
      cIvalid = 1'b0; cOready = 1'b1;
      tick();
      checkOutput("pkt9 partial level", 32'(cLevel), 32'd7);
      checkOutput("pkt9 partial ovalid", 32'(cOvalid), 32'd0);
      checkOutput("pkt9 partial iready", 32'(cIready), 32'd1);
      cOready = 1'b0; cIvalid = 1'b1; cIdata = 8'h68; cIlast = 1'b1;
      tick();
      checkOutput("pkt9 last level", 32'(cLevel), 32'd8);
      checkOutput("pkt9 last ovalid", 32'(cOvalid), 32'd1);
      checkOutput("pkt9 last odata", 32'(cOdata), 32'h61);
      cIvalid = 1'b0; cIlast = 1'b0; cOready = 1'b1;
      for (int j = 0; j < 8; j++) begin
         tick();
         checkOutput($sformatf("pkt9 drain%0d level", j), 32'(cLevel), 32'(7 - j));
         checkOutput($sformatf("pkt9 drain%0d ovalid", j), 32'(cOvalid), 32'(j < 7));
         if (j < 7) begin
            checkOutput($sformatf("pkt9 drain%0d odata", j), 32'(cOdata), 32'(8'h62 + j));
            checkOutput($sformatf("pkt9 drain%0d olast", j), 32'(cOlast), 32'(j == 6));
         end
      end
      cOready = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
